flit_router: RTL and testbench

- Parameterised N-port packet router for 64-bit flits, one flit per port per cycle.
- Each input packet starts with a header flit carrying a destination port and a flit count.
- Each output has a round-robin arbiter that locks onto one input for a whole packet, with valid/backpressure handshakes on both sides.
- Inputs selected by PassThrough skip header decoding and forward to a fixed neighbour output.
- Sits between node-local links in the on-chip fabric.

---
 rtl/router_pkg.sv | 14 +
 rtl/router_rr_arbiter.sv | 58 +++++
 rtl/flit_router.sv | 152 +++++++++++++++
 tb/tb_flit_router.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared types and header field layout for the flit router.
package router_pkg;

    localparam int FLIT_W = 64;
    typedef logic [FLIT_W-1:0] flit_t;

    localparam int HDR_DEST_LSB = 0;
    localparam int HDR_DEST_W   = 8;
    localparam int HDR_LEN_LSB  = 8;
    localparam int HDR_LEN_W    = 8;

    typedef enum logic [1:0] {IDLE, REQ, XFER} in_state_e;

endpackage

// File: rtl/router_rr_arbiter.sv
// Per-output round-robin arbiter that holds its grant for a whole packet.
module router_rr_arbiter #(
    parameter int NumPorts = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NumPorts-1:0] req,
    input  logic                release_lock,
    output logic [NumPorts-1:0] gnt,
    output logic [NumPorts-1:0] owner
);
    localparam int PtrW = $clog2(NumPorts);

    logic [PtrW-1:0] ptr;
    logic [PtrW-1:0] idx;
    logic [PtrW-1:0] gnt_idx;
    logic [PtrW-1:0] ptr_next;
    logic            found;
    logic            locked;

    // Search starts at the pointer and wraps, so the most recent winner goes last.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        idx     = '0;
        found   = 1'b0;
        if (!locked) begin
            for (int k = 0; k < NumPorts; k++) begin
                idx = PtrW'((int'(ptr) + k) % NumPorts);
                if (!found && req[idx]) begin
                    found        = 1'b1;
                    gnt[idx]     = 1'b1;
                    gnt_idx      = idx;
                end
            end
        end
    end

    assign ptr_next = (gnt_idx == PtrW'(NumPorts - 1)) ? '0 : gnt_idx + PtrW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            locked <= 1'b0;
            owner  <= '0;
            ptr    <= '0;
        end else if (locked) begin
            if (release_lock) begin
                locked <= 1'b0;
                owner  <= '0;
            end
        end else if (found) begin
            locked <= 1'b1;
            owner  <= gnt;
            ptr    <= ptr_next;
        end
    end

endmodule

// File: rtl/flit_router.sv
// N-port packet router: header-routed inputs, packet-locked round-robin outputs.
//   state | meaning
//   IDLE  | waiting for a header; latches dest/length without consuming it
//   REQ   | requesting the destination output
//   XFER  | forwarding (or dropping, for an invalid dest) until the last flit
module flit_router
    import router_pkg::*;
#(
    parameter int                  NumPorts    = 4,
    parameter logic [NumPorts-1:0] PassThrough = {NumPorts{1'b0}},
    parameter int                  FlitW       = 64
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NumPorts-1:0][FlitW-1:0] D,
    input  logic [NumPorts-1:0]            D_VALID,
    output logic [NumPorts-1:0]            D_BP,
    output logic [NumPorts-1:0][FlitW-1:0] Q,
    output logic [NumPorts-1:0]            Q_VALID,
    input  logic [NumPorts-1:0]            Q_BP,
    output logic [NumPorts-1:0]            Q_SOF
);
    localparam int PtrW = $clog2(NumPorts);

    in_state_e             state      [NumPorts];
    in_state_e             state_next [NumPorts];
    logic [PtrW-1:0]       dest       [NumPorts];
    logic [HDR_LEN_W-1:0]  rem        [NumPorts];
    logic [HDR_DEST_W-1:0] hdr_dest8  [NumPorts];
    logic [PtrW-1:0]       hdr_dest   [NumPorts];
    logic [HDR_LEN_W-1:0]  hdr_len    [NumPorts];
    flit_t                 fwd_data   [NumPorts];
    logic [NumPorts-1:0]   hdr_ok, drop, sof, accept, last, granted;
    logic [NumPorts-1:0]   load_en, release_lock, fwd_valid, fwd_sof;
    logic [NumPorts-1:0][NumPorts-1:0] req_m, gnt_m, owner_m;

    always_comb begin
        for (int i = 0; i < NumPorts; i++) begin
            hdr_dest8[i] = PassThrough[i] ? HDR_DEST_W'((i + 1) % NumPorts)
                                          : D[i][HDR_DEST_LSB +: HDR_DEST_W];
            hdr_ok[i]    = hdr_dest8[i] < HDR_DEST_W'(NumPorts);
            hdr_dest[i]  = hdr_dest8[i][PtrW-1:0];
            hdr_len[i]   = (D[i][HDR_LEN_LSB +: HDR_LEN_W] == '0) ? HDR_LEN_W'(1)
                                                               : D[i][HDR_LEN_LSB +: HDR_LEN_W];
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < NumPorts; i++) begin
            if (RST) state[i] <= IDLE;
            else     state[i] <= state_next[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NumPorts; i++) begin
            state_next[i] = state[i];
            case (state[i])
                IDLE:    if (D_VALID[i]) state_next[i] = hdr_ok[i] ? REQ : XFER;
                REQ:     if (granted[i]) state_next[i] = XFER;
                XFER:    if (last[i])    state_next[i] = IDLE;
                default: state_next[i] = IDLE;
            endcase
        end
    end

    // A dropped packet drains freely; a routed one only moves when its output can load.
    always_comb begin
        for (int i = 0; i < NumPorts; i++) begin
            D_BP[i] = 1'b1;
            if (!RST && state[i] == XFER && (drop[i] || load_en[dest[i]]))
                D_BP[i] = 1'b0;
            accept[i] = D_VALID[i] && !D_BP[i];
            last[i]   = accept[i] && (rem[i] == HDR_LEN_W'(1));
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < NumPorts; i++) begin
            if (RST) begin
                dest[i] <= '0;
                rem[i]  <= '0;
                drop[i] <= 1'b0;
                sof[i]  <= 1'b0;
            end else if (state[i] == IDLE && D_VALID[i]) begin
                dest[i] <= hdr_dest[i];
                rem[i]  <= hdr_len[i];
                drop[i] <= !hdr_ok[i];
                sof[i]  <= 1'b1;
            end else if (accept[i]) begin
                rem[i]  <= rem[i] - HDR_LEN_W'(1);
                sof[i]  <= 1'b0;
            end
        end
    end

    always_comb begin
        granted      = '0;
        release_lock = '0;
        for (int o = 0; o < NumPorts; o++) begin
            for (int i = 0; i < NumPorts; i++) begin
                req_m[o][i] = (state[i] == REQ) && (dest[i] == PtrW'(o));
                granted[i]  = granted[i] | gnt_m[o][i];
            end
            release_lock[o] = |(owner_m[o] & last & ~drop);
        end
    end

    for (genvar o = 0; o < NumPorts; o++) begin : g_arb
        router_rr_arbiter #(.NumPorts(NumPorts)) u_arb (
            .clk          (CLK),
            .rst          (RST),
            .req          (req_m[o]),
            .release_lock (release_lock[o]),
            .gnt          (gnt_m[o]),
            .owner        (owner_m[o])
        );
    end

    always_comb begin
        for (int o = 0; o < NumPorts; o++) begin
            load_en[o]   = !Q_VALID[o] || !Q_BP[o];
            fwd_valid[o] = 1'b0;
            fwd_sof[o]   = 1'b0;
            fwd_data[o]  = '0;
            for (int i = 0; i < NumPorts; i++) begin
                if (owner_m[o][i] && accept[i] && !drop[i]) begin
                    fwd_valid[o] = 1'b1;
                    fwd_sof[o]   = sof[i];
                    fwd_data[o]  = D[i];
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            Q       <= '0;
            Q_VALID <= '0;
            Q_SOF   <= '0;
        end else begin
            for (int o = 0; o < NumPorts; o++) begin
                if (load_en[o]) begin
                    Q_VALID[o] <= fwd_valid[o];
                    Q_SOF[o]   <= fwd_sof[o];
                    if (fwd_valid[o]) Q[o] <= fwd_data[o];
                end
            end
        end
    end

endmodule

// File: tb/tb_flit_router.sv
// Directed bench for flit_router: routing, arbitration, pass-through, drop, backpressure.
module tb_flit_router;
    import router_pkg::*;

    localparam int N   = 4;
    localparam int LIM = 200;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0][63:0]  d;
    logic [N-1:0]        d_valid;
    logic [N-1:0]        q_bp;
    logic [N-1:0]        d_bp    [2];
    logic [N-1:0][63:0]  q       [2];
    logic [N-1:0]        q_valid [2];
    logic [N-1:0]        q_sof   [2];

    int checks   = 0;
    int failures = 0;

    flit_t  mon_data [2][N][$];
    bit     mon_sof  [2][N][$];
    longint mon_t    [2][N][$];
    int     vcnt     [2][N];
    int     nz_cnt;

    always #5 clk = ~clk;

    flit_router #(.NumPorts(N), .PassThrough(4'b0000)) u_dut (
        .CLK(clk), .RST(rst), .D(d), .D_VALID(d_valid), .D_BP(d_bp[0]),
        .Q(q[0]), .Q_VALID(q_valid[0]), .Q_BP(q_bp), .Q_SOF(q_sof[0])
    );

    flit_router #(.NumPorts(N), .PassThrough(4'b0011)) u_dut_pt (
        .CLK(clk), .RST(rst), .D(d), .D_VALID(d_valid), .D_BP(d_bp[1]),
        .Q(q[1]), .Q_VALID(q_valid[1]), .Q_BP(q_bp), .Q_SOF(q_sof[1])
    );

    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            for (int o = 0; o < N; o++) begin
                if (q_valid[m][o]) vcnt[m][o]++;
                if (q_valid[m][o] && !q_bp[o]) begin
                    mon_data[m][o].push_back(q[m][o]);
                    mon_sof[m][o].push_back(q_sof[m][o]);
                    mon_t[m][o].push_back($time);
                end
            end
        end
        if (q_valid[0] != '0 || q_sof[0] != '0 || q[0] != '0) nz_cnt++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive_slot();
        @(posedge clk);
        #2;
    endtask

    task automatic clear_mon();
        for (int m = 0; m < 2; m++) begin
            for (int o = 0; o < N; o++) begin
                mon_data[m][o].delete();
                mon_sof[m][o].delete();
                mon_t[m][o].delete();
                vcnt[m][o] = 0;
            end
        end
        nz_cnt = 0;
    endtask

    task automatic reset_dut();
        drive_slot();
        rst = 1'b1; d = '0; d_valid = '0; q_bp = '0;
        repeat (3) drive_slot();
        rst = 1'b0;
        clear_mon();
    endtask

    // Presents each flit and waits (bounded) for the watched DUT to accept it.
    task automatic send_pkt(input int m, input int i, input flit_t f[$],
                            output int stalls, output longint t_first);
        int n;
        stalls  = 0;
        t_first = 0;
        foreach (f[k]) begin
            d[i] = f[k];
            d_valid[i] = 1'b1;
            n = 0;
            @(negedge clk);
            while (d_bp[m][i] && n < LIM) begin
                n++;
                @(negedge clk);
            end
            check_eq($sformatf("src%0d_timeout", i), 64'(n >= LIM), 64'd0);
            if (k == 0) t_first = $time;
            stalls += n;
            drive_slot();
        end
        d_valid[i] = 1'b0;
        d[i] = '0;
    endtask

    task automatic check_pkt(input string tag, input int m, input int o,
                             input flit_t exp[$], input bit exp_sof[$]);
        check_eq({tag, "_len"}, 64'(mon_data[m][o].size()), 64'(exp.size()));
        foreach (exp[k]) begin
            if (k < mon_data[m][o].size()) begin
                check_eq($sformatf("%s_flit%0d", tag, k), mon_data[m][o][k], exp[k]);
                check_eq($sformatf("%s_sof%0d", tag, k), 64'(mon_sof[m][o][k]), 64'(exp_sof[k]));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int     st, st0, st3;
        longint t0, t3;
        flit_t  p[$], p0[$], p3[$];
        bit     s[$];

        rst = 1'b1; d = '0; d_valid = '0; q_bp = '0;
        clear_mon();

        // Reset: backpressure everywhere, outputs cleared, then a long idle run.
        repeat (2) drive_slot();
        d_valid = '1;
        #1;
        check_eq("rst_dbp", 64'(d_bp[0]), 64'hF);
        check_eq("rst_dbp_pt", 64'(d_bp[1]), 64'hF);
        d_valid = '0;
        drive_slot();
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_qvalid", 64'(q_valid[0]), 64'd0);
        check_eq("rst_qsof", 64'(q_sof[0]), 64'd0);
        check_eq("rst_q1", q[0][1], 64'd0);
        clear_mon();
        repeat (1000) @(posedge clk);
        check_eq("idle_nonzero", 64'(nz_cnt), 64'd0);

        // Single packet input 2 -> output 1.
        reset_dut();
        p = '{64'h0000_0000_0000_0301, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888};
        s = '{1'b1, 1'b0, 1'b0};
        send_pkt(0, 2, p, st, t0);
        repeat (4) drive_slot();
        check_pkt("t2", 0, 1, p, s);
        check_eq("t2_stall", 64'(st), 64'd2);
        if (mon_t[0][1].size() > 0)
            check_eq("t2_latency", 64'(mon_t[0][1][0] - t0), 64'd10);
        for (int k = 1; k < mon_t[0][1].size(); k++)
            check_eq("t2_gap", 64'(mon_t[0][1][k] - mon_t[0][1][k-1]), 64'd10);
        check_eq("t2_v0", 64'(vcnt[0][0]), 64'd0);
        check_eq("t2_v2", 64'(vcnt[0][2]), 64'd0);
        check_eq("t2_v3", 64'(vcnt[0][3]), 64'd0);
        check_eq("t2_v1", 64'(vcnt[0][1]), 64'd3);

        // Contention: inputs 0 and 3 to output 2 in the same cycle.
        reset_dut();
        p0 = '{64'hAA00_0000_0000_0202, 64'hAAAA_0000_0000_0001};
        p3 = '{64'hCC00_0000_0000_0202, 64'hCCCC_0000_0000_0003};
        fork
            send_pkt(0, 0, p0, st0, t0);
            send_pkt(0, 3, p3, st3, t3);
        join
        repeat (3) drive_slot();
        p = '{p0[0], p0[1], p3[0], p3[1]};
        s = '{1'b1, 1'b0, 1'b1, 1'b0};
        check_pkt("t3", 0, 2, p, s);
        check_eq("t3_stall_in0", 64'(st0), 64'd2);
        check_eq("t3_stall_in3", 64'(st3), 64'd5);
        check_eq("t3_v1", 64'(vcnt[0][1]), 64'd0);

        // Pass-through on inputs 0/1: input 1 goes to output 2 regardless of dest.
        reset_dut();
        p0 = '{64'h1100_0000_0000_0203, 64'h1111_0000_0000_0011};
        p3 = '{64'h2200_0000_0000_0203, 64'h2222_0000_0000_0022};
        s  = '{1'b1, 1'b0};
        fork
            send_pkt(1, 1, p0, st0, t0);
            send_pkt(1, 2, p3, st3, t3);
        join
        repeat (3) drive_slot();
        check_pkt("t4_pt", 1, 2, p0, s);
        check_pkt("t4_np", 1, 3, p3, s);
        check_eq("t4_v0", 64'(vcnt[1][0]), 64'd0);
        check_eq("t4_v1", 64'(vcnt[1][1]), 64'd0);

        // Invalid destination: consumed and dropped.
        reset_dut();
        p = '{64'h0000_0000_0000_0407, 64'hD1, 64'hD2, 64'hD3};
        send_pkt(0, 0, p, st, t0);
        repeat (3) drive_slot();
        check_eq("t5_stall", 64'(st), 64'd1);
        for (int o = 0; o < N; o++)
            check_eq($sformatf("t5_v%0d", o), 64'(vcnt[0][o]), 64'd0);

        // LEN=0 acts as a 1-flit packet, followed by a LEN=1 packet.
        reset_dut();
        p0 = '{64'hE000_0000_0000_0003};
        p3 = '{64'hF000_0000_0000_0103};
        send_pkt(0, 1, p0, st0, t0);
        send_pkt(0, 1, p3, st3, t3);
        repeat (3) drive_slot();
        p = '{p0[0], p3[0]};
        s = '{1'b1, 1'b1};
        check_pkt("t6_len0", 0, 3, p, s);
        check_eq("t6_stall_a", 64'(st0), 64'd2);
        check_eq("t6_stall_b", 64'(st3), 64'd2);

        // Output backpressure for 5 cycles mid-packet.
        reset_dut();
        p = '{64'h0000_0000_0000_0601, 64'hB1, 64'hB2, 64'hB3, 64'hB4, 64'hB5};
        s = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        fork
            send_pkt(0, 0, p, st, t0);
            begin
                repeat (4) @(posedge clk);
                #2;
                q_bp[1] = 1'b1;
                repeat (5) begin
                    @(negedge clk);
                    check_eq("t7_hold_q", q[0][1], p[1]);
                    check_eq("t7_hold_v", 64'(q_valid[0][1]), 64'd1);
                    check_eq("t7_hold_dbp", 64'(d_bp[0][0]), 64'd1);
                end
                drive_slot();
                q_bp[1] = 1'b0;
            end
        join
        repeat (3) drive_slot();
        check_pkt("t7", 0, 1, p, s);
        check_eq("t7_stall", 64'(st), 64'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
